// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forwarding select encodings, hazard tracking
// entry and the hazard controller's per-cycle decision.
package cpu_pkg;

  // Destination register width carried by a tracking entry.
  localparam int unsigned TRACK_RD_W = 5;

  // Operand select encodings driven on FWD_SEL (3 is never used).
  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_WB    = 2'd2;

  // Per-cycle pipeline decision, highest priority last.
  typedef enum logic [1:0] {
    RUN,
    LOAD_USE,
    FLUSH,
    FREEZE
  } hazard_state_t;

  // One in-flight instruction as seen by the hazard unit.
  typedef struct packed {
    logic                  valid;
    logic [TRACK_RD_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } track_entry_t;

  // x0 writes are architecturally discarded, so they never produce anything.
  function automatic logic is_producer(input track_entry_t e);
    return e.valid && e.reg_write && (e.rd != '0);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Pipeline <-> hazard controller signal bundle.
interface pipe_hazard_unit_if #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                          ID_VALID;
  logic [NUM_SRC*REG_ADDR_W-1:0] ID_RS;
  logic [NUM_SRC-1:0]            ID_RS_USED;
  logic [REG_ADDR_W-1:0]         ID_RD;
  logic                          ID_REG_WRITE;
  logic                          ID_MEM_READ;
  logic                          BUSYWAIT;
  logic                          BRANCH_TAKEN;
  logic                          CNT_CLR;
  logic                          STALL;
  logic                          BUBBLE;
  logic                          FLUSH;
  logic [2*NUM_SRC-1:0]          FWD_SEL;
  logic [CNT_W-1:0]              STALL_CNT;
  logic [CNT_W-1:0]              FLUSH_CNT;

  // Pipeline side: describes the ID instruction, consumes the controls.
  modport master (
    output ID_VALID, ID_RS, ID_RS_USED, ID_RD, ID_REG_WRITE, ID_MEM_READ,
    output BUSYWAIT, BRANCH_TAKEN, CNT_CLR,
    input  STALL, BUBBLE, FLUSH, FWD_SEL, STALL_CNT, FLUSH_CNT
  );

  // Hazard controller side.
  modport slave (
    input  ID_VALID, ID_RS, ID_RS_USED, ID_RD, ID_REG_WRITE, ID_MEM_READ,
    input  BUSYWAIT, BRANCH_TAKEN, CNT_CLR,
    output STALL, BUBBLE, FLUSH, FWD_SEL, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/hazard_track_stage.sv
// One hazard tracking entry (EX, MEM or WB copy of an in-flight instruction).
module hazard_track_stage
  import cpu_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         hold_i,
  input  logic         clear_i,
  input  track_entry_t d_i,
  output track_entry_t q_o
);

  track_entry_t entry_q;

  // Hold wins over clear; clear loads an empty (invalid) entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else if (!hold_i) begin
      entry_q <= clear_i ? '0 : d_i;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Centralised hazard controller: load-use interlock, branch squash, memory
// freeze, decode-time forwarding selects and saturating perf counters.
module pipe_hazard_unit
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input logic               CLK,
  input logic               RESET,
  pipe_hazard_unit_if.slave hz
);

  track_entry_t  ex_q, mem_q, wb_q;
  track_entry_t  id_entry, mem_d;
  hazard_state_t state;
  logic          st_freeze, st_flush, st_load_use, st_run;
  logic          load_use;

  logic [NUM_SRC-1:0]   match_ex, match_mem;
  logic [2*NUM_SRC-1:0] fwd_sel_d, fwd_sel_q;
  logic [CNT_W-1:0]     stall_cnt_q, flush_cnt_q;

  assign id_entry.valid     = hz.ID_VALID;
  assign id_entry.rd        = TRACK_RD_W'(hz.ID_RD);
  assign id_entry.reg_write = hz.ID_REG_WRITE;
  assign id_entry.is_load   = hz.ID_MEM_READ;

  // Per-port source compare against the EX and MEM producers.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [TRACK_RD_W-1:0] rs;
    assign rs = TRACK_RD_W'(hz.ID_RS[i*REG_ADDR_W +: REG_ADDR_W]);
    assign match_ex[i]  = hz.ID_RS_USED[i] && is_producer(ex_q) && (rs == ex_q.rd);
    assign match_mem[i] = hz.ID_RS_USED[i] && is_producer(mem_q) && (rs == mem_q.rd);
    // Youngest producer wins; a WB producer is covered by the write-first regfile.
    assign fwd_sel_d[2*i +: 2] = !st_run      ? FWD_REG   :
                                 match_ex[i]  ? FWD_EXMEM :
                                 match_mem[i] ? FWD_WB    : FWD_REG;
  end

  assign load_use = hz.ID_VALID && is_producer(ex_q) && ex_q.is_load && (|match_ex);

  // Priority decode: freeze over flush over load-use over run.
  always_comb begin
    state = RUN;
    if (hz.BUSYWAIT) begin
      state = FREEZE;
    end else if (hz.BRANCH_TAKEN) begin
      state = FLUSH;
    end else if (load_use) begin
      state = LOAD_USE;
    end
  end

  assign st_freeze   = (state == FREEZE);
  assign st_flush    = (state == FLUSH);
  assign st_load_use = (state == LOAD_USE);
  assign st_run      = (state == RUN);

  assign hz.STALL  = st_freeze || st_load_use;
  assign hz.BUBBLE = st_load_use;
  assign hz.FLUSH  = st_flush;

  // On a flush the instruction leaving EX was fetched past the branch: squash it.
  always_comb begin
    mem_d = ex_q;
    if (st_flush) begin
      mem_d.valid = 1'b0;
    end
  end

  hazard_track_stage u_ex (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .hold_i  (st_freeze),
    .clear_i (st_flush || st_load_use),
    .d_i     (id_entry),
    .q_o     (ex_q)
  );

  hazard_track_stage u_mem (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .hold_i  (st_freeze),
    .clear_i (1'b0),
    .d_i     (mem_d),
    .q_o     (mem_q)
  );

  hazard_track_stage u_wb (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .hold_i  (st_freeze),
    .clear_i (1'b0),
    .d_i     (mem_q),
    .q_o     (wb_q)
  );

  // Forwarding selects travel with the ID/EX register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fwd_sel_q <= '0;
    end else if (!st_freeze) begin
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign hz.FWD_SEL = fwd_sel_q;

  // Saturating counters; a clear beats a same-cycle increment.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (hz.CNT_CLR) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (st_load_use && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (st_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign hz.STALL_CNT = stall_cnt_q;
  assign hz.FLUSH_CNT = flush_cnt_q;

  // The WB entry only exists to keep the shift chain complete.
  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit; narrow counters make saturation reachable.
module tb_pipe_hazard_unit;

  localparam int unsigned NumSrc   = 2;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned CntW     = 3;

  logic CLK;
  logic RESET;
  int   tests;
  int   fails;

  pipe_hazard_unit_if #(
    .NUM_SRC    (NumSrc),
    .REG_ADDR_W (RegAddrW),
    .CNT_W      (CntW)
  ) hz ();

  pipe_hazard_unit #(
    .NUM_SRC    (NumSrc),
    .REG_ADDR_W (RegAddrW),
    .CNT_W      (CntW)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .hz    (hz)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present an ID-stage instruction and let combinational outputs settle.
  task automatic id_set(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd, input logic rw,
                        input logic ld);
    hz.ID_VALID     = v;
    hz.ID_RS        = {rs1, rs0};
    hz.ID_RS_USED   = used;
    hz.ID_RD        = rd;
    hz.ID_REG_WRITE = rw;
    hz.ID_MEM_READ  = ld;
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic b, input logic f);
    chk({tag, "_stall"}, {31'd0, hz.STALL}, {31'd0, s});
    chk({tag, "_bubble"}, {31'd0, hz.BUBBLE}, {31'd0, b});
    chk({tag, "_flush"}, {31'd0, hz.FLUSH}, {31'd0, f});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RESET = 1'b1;
    hz.BUSYWAIT = 1'b0;
    hz.BRANCH_TAKEN = 1'b0;
    hz.CNT_CLR = 1'b0;
    id_set(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    #2;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_fwd", 32'(hz.FWD_SEL), 32'd0);
    chk("reset_scnt", 32'(hz.STALL_CNT), 32'd0);
    chk("reset_fcnt", 32'(hz.FLUSH_CNT), 32'd0);
    @(posedge CLK);
    #2;
    RESET = 1'b0;

    // lw x5 ; add x6,x5,x7 -> one load-use stall, then WB forward on port 0
    id_set(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1);
    chk("lw_id_stall", 32'(hz.STALL), 32'd0);
    tick();
    id_set(1'b1, 5'd5, 5'd7, 2'b11, 5'd6, 1'b1, 1'b0);
    chk_ctl("lu", 1'b1, 1'b1, 1'b0);
    tick();
    chk("lu_scnt", 32'(hz.STALL_CNT), 32'd1);
    chk("lu_fwd_bubble", 32'(hz.FWD_SEL), 32'd0);
    chk_ctl("lu_after", 1'b0, 1'b0, 1'b0);
    tick();
    chk("lu_fwd", 32'(hz.FWD_SEL), 32'b0010);

    // add x5 ; sub x8,x5,x5 -> EX/MEM forward on both ports
    id_set(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 5'd5, 5'd5, 2'b11, 5'd8, 1'b1, 1'b0);
    chk("alu_stall", 32'(hz.STALL), 32'd0);
    tick();
    chk("alu_fwd_exmem", 32'(hz.FWD_SEL), 32'b0101);

    // One unrelated instruction in between -> WB forward on both ports
    id_set(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 5'd1, 5'd2, 2'b11, 5'd9, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 5'd5, 5'd5, 2'b11, 5'd8, 1'b1, 1'b0);
    chk("gap_stall", 32'(hz.STALL), 32'd0);
    tick();
    chk("gap_fwd_wb", 32'(hz.FWD_SEL), 32'b1010);

    // x0 destinations never forward or stall
    id_set(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 5'd0, 5'd0, 2'b11, 5'd1, 1'b1, 1'b0);
    chk("x0_stall", 32'(hz.STALL), 32'd0);
    tick();
    chk("x0_fwd", 32'(hz.FWD_SEL), 32'd0);
    id_set(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1);
    tick();
    id_set(1'b1, 5'd0, 5'd0, 2'b11, 5'd2, 1'b1, 1'b0);
    chk("x0_load_stall", 32'(hz.STALL), 32'd0);
    tick();

    // Taken branch with x10 in EX and x11 in ID: both squashed
    id_set(1'b1, 5'd1, 5'd2, 2'b11, 5'd10, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 5'd1, 5'd2, 2'b11, 5'd11, 1'b1, 1'b0);
    hz.BRANCH_TAKEN = 1'b1;
    #1;
    chk_ctl("br", 1'b0, 1'b0, 1'b1);
    tick();
    hz.BRANCH_TAKEN = 1'b0;
    chk("br_fcnt", 32'(hz.FLUSH_CNT), 32'd1);
    chk("br_fwd_zero", 32'(hz.FWD_SEL), 32'd0);
    id_set(1'b1, 5'd10, 5'd11, 2'b11, 5'd12, 1'b1, 1'b0);
    chk_ctl("br_after", 1'b0, 1'b0, 1'b0);
    tick();
    chk("br_reader_fwd", 32'(hz.FWD_SEL), 32'd0);

    // lw x5 (reads x12 from EX) ; add x6,x5,x3 under a 4-cycle busywait
    id_set(1'b1, 5'd12, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1);
    tick();
    chk("bw_pre_fwd", 32'(hz.FWD_SEL), 32'b0001);
    id_set(1'b1, 5'd5, 5'd3, 2'b11, 5'd6, 1'b1, 1'b0);
    hz.BUSYWAIT = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_ctl("bw", 1'b1, 1'b0, 1'b0);
      tick();
      chk("bw_fwd_hold", 32'(hz.FWD_SEL), 32'b0001);
      chk("bw_scnt_hold", 32'(hz.STALL_CNT), 32'd1);
    end
    hz.BUSYWAIT = 1'b0;
    #1;
    chk_ctl("bw_lu", 1'b1, 1'b1, 1'b0);
    tick();
    chk("bw_scnt", 32'(hz.STALL_CNT), 32'd2);
    chk("bw_fwd_bubble", 32'(hz.FWD_SEL), 32'd0);
    chk_ctl("bw_run", 1'b0, 1'b0, 1'b0);
    tick();
    chk("bw_fwd", 32'(hz.FWD_SEL), 32'b0010);

    // Asynchronous reset in the middle of a load-use stall
    id_set(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
    tick();
    id_set(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
    chk("rst_pre_stall", 32'(hz.STALL), 32'd1);
    RESET = 1'b1;
    #1;
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_fwd", 32'(hz.FWD_SEL), 32'd0);
    chk("rst_scnt", 32'(hz.STALL_CNT), 32'd0);
    chk("rst_fcnt", 32'(hz.FLUSH_CNT), 32'd0);
    RESET = 1'b0;
    #1;
    chk("rst_first_run", 32'(hz.STALL), 32'd0);
    tick();

    // Clear beats a same-cycle stall increment
    id_set(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
    tick();
    id_set(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
    hz.CNT_CLR = 1'b1;
    #1;
    chk("clr_stall", 32'(hz.STALL), 32'd1);
    tick();
    hz.CNT_CLR = 1'b0;
    chk("clr_scnt", 32'(hz.STALL_CNT), 32'd0);
    tick();

    // Flush counter saturates at 7
    for (int k = 0; k < 9; k++) begin
      hz.BRANCH_TAKEN = 1'b1;
      tick();
      hz.BRANCH_TAKEN = 1'b0;
      tick();
    end
    chk("sat_fcnt", 32'(hz.FLUSH_CNT), 32'd7);

    // Stall counter saturates at 7
    for (int k = 0; k < 9; k++) begin
      id_set(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
      tick();
      id_set(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
      tick();
      tick();
    end
    chk("sat_scnt", 32'(hz.STALL_CNT), 32'd7);
    chk("sat_fcnt_hold", 32'(hz.FLUSH_CNT), 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
